unary_adder_sequencer: RTL

Sequences one scaled unary addition through the two-input unary adder. Accepts two binary operands on a start handshake and clears the adder. Converts each operand into an INPUT_WIDTH-bit unary bitstream that drives the adder's a/b/ready inputs, then counts the adder's valid output bits back into a binary result. Sits between the binary control/datapath and the unary adder instance.

---
 rtl/unary_adder_sequencer_if.sv | 54 +++++
 rtl/unary_adder_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/unary_adder_sequencer_if.sv
// ---------------------------------------------------------------------------
// unary_adder_sequencer_if
//
// Purpose: bundles the control-side start/operand/result signals and the
// unary adder drive/return signals of unary_adder_sequencer into one port.
//
// Signals (as seen from the sequencer through the slave modport):
//   start, abort         in   operation request / cancel
//   a_val, b_val         in   binary operand ones counts
//   busy                 out  high whenever the sequencer is not idle
//   result_valid         out  one-cycle result pulse
//   result_ones          out  captured adder output ones
//   result_bits          out  captured adder output bits that were valid
//   add_rst_n            out  adder active-low reset
//   add_a, add_b         out  unary operand bits
//   add_ready            out  {b, a} bit-present strobes
//   add_valid, add_y     in   adder output valid / output bit
//
// The master modport is the view of whoever drives the requests and models
// the adder (the surrounding datapath, or a testbench).
// ---------------------------------------------------------------------------
interface unary_adder_sequencer_if #(
  parameter int INPUT_WIDTH = 32,
  parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
);

  logic                   start;
  logic                   abort;
  logic [COUNT_WIDTH-1:0] a_val;
  logic [COUNT_WIDTH-1:0] b_val;
  logic                   busy;
  logic                   result_valid;
  logic [COUNT_WIDTH-1:0] result_ones;
  logic [COUNT_WIDTH-1:0] result_bits;
  logic                   add_rst_n;
  logic                   add_a;
  logic                   add_b;
  logic [1:0]             add_ready;
  logic                   add_valid;
  logic                   add_y;

  modport slave (
    input  start, abort, a_val, b_val, add_valid, add_y,
    output busy, result_valid, result_ones, result_bits,
           add_rst_n, add_a, add_b, add_ready
  );

  modport master (
    output start, abort, a_val, b_val, add_valid, add_y,
    input  busy, result_valid, result_ones, result_bits,
           add_rst_n, add_a, add_b, add_ready
  );

endinterface

// File: rtl/unary_adder_sequencer.sv
// ---------------------------------------------------------------------------
// unary_adder_sequencer
//
// Purpose: runs one scaled unary addition through a two-input unary adder.
// On an accepted start it latches (and clamps) two binary operands, resets
// the adder for one cycle, streams each operand as an INPUT_WIDTH-bit unary
// bitstream into the adder, and counts the adder's valid output bits (and
// the ones among them) back into binary results.
//
// Ports:
//   i_clk     single clock, rising edge
//   i_reset   synchronous active-high reset
//   io_bus    unary_adder_sequencer_if.slave (control + adder signals)
//
// Build option:
//   UNARY_SEQ_INTERLEAVE_EN  when defined, operands are emitted in spread
//                            order using a per-operand accumulator; when
//                            undefined, thermometer order (ones first).
// ---------------------------------------------------------------------------
module unary_adder_sequencer #(
  parameter int INPUT_WIDTH = 32,
  parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  unary_adder_sequencer_if.slave      io_bus
);

  localparam logic [COUNT_WIDTH-1:0] LP_N    = COUNT_WIDTH'(INPUT_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] LP_LAST = COUNT_WIDTH'(INPUT_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]             r_state;
  logic [COUNT_WIDTH-1:0] r_k;
  logic [COUNT_WIDTH-1:0] r_a_lat;
  logic [COUNT_WIDTH-1:0] r_b_lat;
  logic                   r_cap_en;
  logic [COUNT_WIDTH-1:0] r_res_ones;
  logic [COUNT_WIDTH-1:0] r_res_bits;
  logic                   r_busy;
  logic                   r_result_valid;
  logic                   r_add_rst_n;
  logic                   r_add_a;
  logic                   r_add_b;
  logic [1:0]             r_add_ready;

  logic [2:0]             w_next_state;
  logic                   w_accept;
  logic                   w_emit;
  logic                   w_capture;
  logic                   w_bit_a;
  logic                   w_bit_b;
  logic [COUNT_WIDTH-1:0] w_a_clamp;
  logic [COUNT_WIDTH-1:0] w_b_clamp;

  // Operands above the stream length cannot be represented in the stream,
  // so they saturate at INPUT_WIDTH before being latched.
  assign w_a_clamp = (io_bus.a_val > LP_N) ? LP_N : io_bus.a_val;
  assign w_b_clamp = (io_bus.b_val > LP_N) ? LP_N : io_bus.b_val;

  // Next-state logic. Abort overrides every transition outside IDLE, and in
  // IDLE it also suppresses a simultaneous start.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (io_bus.start && !io_bus.abort) w_next_state = S_CLEAR;
      S_CLEAR:  w_next_state = S_STREAM;
      S_STREAM: if (r_k == LP_LAST) w_next_state = S_FLUSH;
      S_FLUSH:  w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
    if ((r_state != S_IDLE) && io_bus.abort) begin
      w_next_state = S_IDLE;
    end
  end

  assign w_accept = (r_state == S_IDLE) && (w_next_state == S_CLEAR);

  // Every output is registered from the next state, so the stream bit for
  // STREAM cycle k is computed on the edge that enters that cycle.
  assign w_emit = (w_next_state == S_STREAM);

  // Samples are only counted while an operation is actually in flight; the
  // capture-enable copy of add_ready still lingers for one cycle after an
  // abort and must not disturb the partial result.
  assign w_capture = r_cap_en && io_bus.add_valid &&
                     ((r_state == S_STREAM) || (r_state == S_FLUSH));

`ifdef UNARY_SEQ_INTERLEAVE_EN
  localparam logic [COUNT_WIDTH:0] LP_N_ACC = {1'b0, LP_N};

  logic [COUNT_WIDTH:0] r_acc_a;
  logic [COUNT_WIDTH:0] r_acc_b;
  logic [COUNT_WIDTH:0] w_sum_a;
  logic [COUNT_WIDTH:0] w_sum_b;

  // Spread emission: a fractional accumulator overflows exactly val times in
  // INPUT_WIDTH steps, each overflow producing a one.
  assign w_sum_a = r_acc_a + {1'b0, r_a_lat};
  assign w_sum_b = r_acc_b + {1'b0, r_b_lat};
  assign w_bit_a = (w_sum_a >= LP_N_ACC);
  assign w_bit_b = (w_sum_b >= LP_N_ACC);

  // Accumulators start from zero for each operation and step once per
  // emitted stream bit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc_a <= '0;
      r_acc_b <= '0;
    end else if (w_accept) begin
      r_acc_a <= '0;
      r_acc_b <= '0;
    end else if (w_emit) begin
      r_acc_a <= w_bit_a ? (w_sum_a - LP_N_ACC) : w_sum_a;
      r_acc_b <= w_bit_b ? (w_sum_b - LP_N_ACC) : w_sum_b;
    end
  end
`else
  logic [COUNT_WIDTH-1:0] w_k_emit;

  // Thermometer emission: the index of the STREAM cycle being entered is
  // compared against each operand, so the ones come first.
  assign w_k_emit = (r_state == S_STREAM) ? (r_k + 1'b1) : '0;
  assign w_bit_a  = (w_k_emit < r_a_lat);
  assign w_bit_b  = (w_k_emit < r_b_lat);
`endif

  // Main sequencing registers: state, stream index, latched operands, the
  // registered adder drive and the status outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_k            <= '0;
      r_a_lat        <= '0;
      r_b_lat        <= '0;
      r_cap_en       <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_add_rst_n    <= 1'b0;
      r_add_a        <= 1'b0;
      r_add_b        <= 1'b0;
      r_add_ready    <= 2'b00;
    end else begin
      r_state        <= w_next_state;
      r_busy         <= (w_next_state != S_IDLE);
      r_result_valid <= (w_next_state == S_DONE);
      r_add_rst_n    <= (w_next_state != S_CLEAR);
      r_add_ready    <= w_emit ? 2'b11 : 2'b00;
      r_add_a        <= w_emit & w_bit_a;
      r_add_b        <= w_emit & w_bit_b;
      r_cap_en       <= (r_add_ready != 2'b00);
      if (w_accept) begin
        r_a_lat <= w_a_clamp;
        r_b_lat <= w_b_clamp;
        r_k     <= '0;
      end else if ((r_state == S_STREAM) && w_emit) begin
        r_k <= r_k + 1'b1;
      end
    end
  end

  // Result counters are cleared on entry to CLEAR and otherwise only move on
  // captured samples; they saturate so a misbehaving adder cannot wrap them.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_res_ones <= '0;
      r_res_bits <= '0;
    end else if (w_accept) begin
      r_res_ones <= '0;
      r_res_bits <= '0;
    end else if (w_capture) begin
      if (r_res_bits != LP_N) begin
        r_res_bits <= r_res_bits + 1'b1;
      end
      if (io_bus.add_y && (r_res_ones != LP_N)) begin
        r_res_ones <= r_res_ones + 1'b1;
      end
    end
  end

  assign io_bus.busy         = r_busy;
  assign io_bus.result_valid = r_result_valid;
  assign io_bus.result_ones  = r_res_ones;
  assign io_bus.result_bits  = r_res_bits;
  assign io_bus.add_rst_n    = r_add_rst_n;
  assign io_bus.add_a        = r_add_a;
  assign io_bus.add_b        = r_add_b;
  assign io_bus.add_ready    = r_add_ready;

endmodule
